// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - asynchronous FIFO write-side controller (binary pointer, level, full/overflow flags)
// Optional almost-full flag enabled by macro FIFO_WR_ALMOST_FULL_EN.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH:0]   rd_ptr_sync,
  input  logic                  ovf_clr,
  output logic [ADDR_WIDTH:0]   wr_ptr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_cnt,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);

  logic                accept;
  logic [ADDR_WIDTH:0] wr_ptr_next;
  logic [ADDR_WIDTH:0] level_next;

  // rst_n gates the enable so the RAM never sees a write while reset is held
  assign accept      = wr_en & ~full & rst_n;
  assign mem_we      = accept;
  assign mem_waddr   = wr_ptr[ADDR_WIDTH-1:0];
  assign mem_wdata   = wr_data;
  assign wr_ptr_next = accept ? wr_ptr + 1'b1 : wr_ptr;
  assign level_next  = wr_ptr_next - rd_ptr_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      wr_cnt   <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_next;
      wr_cnt <= level_next;
      full   <= (level_next == DEPTH_CNT);
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH+1)'(AF_LEVEL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (level_next >= AF_CNT);
    end
  end
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - self-checking bench for fifo_wr_ctrl against a pointer-arithmetic model
module tb_fifo_wr_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;
  localparam int AF    = 14;
`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [AW:0]   rd_ptr_sync;
  logic          ovf_clr;
  logic [AW:0]   wr_ptr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_cnt;
  logic          overflow;

  fifo_wr_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .rd_ptr_sync(rd_ptr_sync), .ovf_clr(ovf_clr), .wr_ptr(wr_ptr),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .full(full), .almost_full(almost_full), .wr_cnt(wr_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model: pointers as integers modulo 32, level = writes outstanding
  int m_wp, m_rp, m_cnt;
  bit m_full, m_af, m_ovf;

  logic          o_we;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata;
  bit            e_we;
  int            e_waddr;

  task automatic model_clear();
    m_wp = 0; m_rp = 0; m_cnt = 0;
    m_full = 0; m_af = 0; m_ovf = 0;
  endtask

  task automatic tick(input bit we, input logic [DW-1:0] d, input int rp, input bit clr);
    @(negedge clk);
    wr_en = we; wr_data = d; rd_ptr_sync = (AW+1)'(rp % PMOD); ovf_clr = clr;
    #1;
    o_we = mem_we; o_waddr = mem_waddr; o_wdata = mem_wdata;
    e_we = we && !m_full && rst_n;
    e_waddr = m_wp % DEPTH;
    @(posedge clk);
    if (rst_n) begin
      if (we && m_full) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (e_we) m_wp = (m_wp + 1) % PMOD;
      m_rp = rp % PMOD;
      m_cnt = (m_wp - m_rp + PMOD) % PMOD;
      m_full = (m_cnt == DEPTH);
      m_af = AF_EN && (m_cnt >= AF);
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; wr_en = 0; ovf_clr = 0; rd_ptr_sync = '0;
    model_clear();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; wr_en = 1; wr_data = 8'hA5; rd_ptr_sync = '0; ovf_clr = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({wr_ptr, wr_cnt, full, almost_full, overflow, mem_we} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: wr_ptr=%0d wr_cnt=%0d full=%b af=%b ovf=%b we=%b, required all 0",
               wr_ptr, wr_cnt, full, almost_full, overflow, mem_we);
    end
    @(negedge clk);
    wr_en = 0;
    rst_n = 1;
  endtask

  task automatic test_fill();
    logic [DW-1:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      d = DW'($urandom);
      tick(1, d, 0, 0);
      tests++;
      if (o_we !== 1'b1 || o_waddr !== AW'(i) || o_wdata !== d) begin
        fails++;
        $display("FAIL fill_write%0d: we=%b addr=%0d data=%h, required we=1 addr=%0d data=%h",
                 i, o_we, o_waddr, o_wdata, i, d);
      end
      tests++;
      if (wr_ptr !== (AW+1)'(i + 1) || wr_cnt !== (AW+1)'(i + 1)) begin
        fails++;
        $display("FAIL fill_ptr%0d: wr_ptr=%0d wr_cnt=%0d, required %0d", i, wr_ptr, wr_cnt, i + 1);
      end
    end
    tests++;
    if (full !== 1'b1 || wr_cnt !== 5'd16 || wr_ptr !== 5'd16 || almost_full !== AF_EN) begin
      fails++;
      $display("FAIL fill_full: full=%b wr_cnt=%0d wr_ptr=%0d af=%b, required 1 16 16 %b",
               full, wr_cnt, wr_ptr, almost_full, AF_EN);
    end
    tick(1, 8'h3C, 0, 0);
    tests++;
    if (o_we !== 1'b0 || overflow !== 1'b1 || wr_ptr !== 5'd16) begin
      fails++;
      $display("FAIL fill_overflow: we=%b ovf=%b wr_ptr=%0d, required 0 1 16", o_we, overflow, wr_ptr);
    end
  endtask

  task automatic test_ovf_clr();
    tick(1, 8'h11, 0, 1);
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_set_wins: overflow=%b, required 1", overflow);
    end
    tick(0, 8'h00, 0, 1);
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear: overflow=%b, required 0", overflow);
    end
  endtask

  task automatic test_release();
    tick(0, 8'h00, 1, 0);
    tests++;
    if (full !== 1'b0 || wr_cnt !== 5'd15) begin
      fails++;
      $display("FAIL release_full: full=%b wr_cnt=%0d, required 0 15", full, wr_cnt);
    end
    tick(1, 8'h77, 1, 0);
    tests++;
    if (o_we !== 1'b1 || o_waddr !== 4'd0 || full !== 1'b1 || wr_cnt !== 5'd16) begin
      fails++;
      $display("FAIL release_write: we=%b addr=%0d full=%b cnt=%0d, required 1 0 1 16",
               o_we, o_waddr, full, wr_cnt);
    end
    tick(0, 8'h00, 2, 0);
    tick(1, 8'h99, 3, 0);
    tests++;
    if (o_we !== 1'b1 || wr_cnt !== 5'd15 || full !== 1'b0 || wr_ptr !== 5'd18) begin
      fails++;
      $display("FAIL simultaneous_wr_rd: we=%b cnt=%0d full=%b wr_ptr=%0d, required 1 15 0 18",
               o_we, wr_cnt, full, wr_ptr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 9; i++) tick(1, DW'(i), 0, 0);
    tests++;
    if (wr_cnt !== 5'd9) begin
      fails++;
      $display("FAIL pre_reset_cnt: wr_cnt=%0d, required 9", wr_cnt);
    end
    @(negedge clk);
    wr_en = 1;
    #2;
    rst_n = 0;
    model_clear();
    #1;
    tests++;
    if ({wr_ptr, wr_cnt, full, almost_full, overflow, mem_we} !== '0) begin
      fails++;
      $display("FAIL reset_async: wr_ptr=%0d wr_cnt=%0d full=%b af=%b ovf=%b we=%b, required all 0",
               wr_ptr, wr_cnt, full, almost_full, overflow, mem_we);
    end
    @(negedge clk);
    wr_en = 0;
    rst_n = 1;
  endtask

  task automatic test_wrap();
    bit seen_31 = 0, seen_wrap = 0;
    int rp;
    for (int k = 0; k < 40; k++) begin
      rp = (k >= 3) ? k - 3 : 0;
      tick(1, DW'($urandom), rp, 0);
      if (wr_ptr == 5'd31) seen_31 = 1;
      if (seen_31 && wr_ptr == 5'd0) seen_wrap = 1;
      tests++;
      if (full !== 1'b0 || wr_cnt !== (AW+1)'(m_cnt) || wr_ptr !== (AW+1)'(m_wp)) begin
        fails++;
        $display("FAIL wrap_step%0d: full=%b cnt=%0d wr_ptr=%0d, required 0 %0d %0d",
                 k, full, wr_cnt, wr_ptr, m_cnt, m_wp);
      end
    end
    tests++;
    if (!seen_wrap || wr_ptr !== 5'd8) begin
      fails++;
      $display("FAIL wrap_seen: wrapped=%b wr_ptr=%0d, required 1 8", seen_wrap, wr_ptr);
    end
  endtask

  task automatic test_random();
    int rp, avail, adv;
    bit we, clr;
    logic [DW-1:0] d;
    rp = m_rp;
    for (int n = 0; n < 400; n++) begin
      avail = (m_wp - rp + PMOD) % PMOD;
      adv = ($urandom_range(0, 9) < 3) ? $urandom_range(0, (avail < 3) ? avail : 3) : 0;
      rp = (rp + adv) % PMOD;
      we = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 9) == 0);
      d = DW'($urandom);
      tick(we, d, rp, clr);
      tests++;
      if (o_we !== e_we || (e_we && (o_waddr !== AW'(e_waddr) || o_wdata !== d))) begin
        fails++;
        $display("FAIL rand_comb%0d: we=%b addr=%0d data=%h, required we=%b addr=%0d data=%h",
                 n, o_we, o_waddr, o_wdata, e_we, e_waddr, d);
      end
      tests++;
      if (wr_ptr !== (AW+1)'(m_wp) || wr_cnt !== (AW+1)'(m_cnt) || full !== m_full ||
          almost_full !== m_af || overflow !== m_ovf) begin
        fails++;
        $display("FAIL rand_reg%0d: ptr=%0d cnt=%0d full=%b af=%b ovf=%b, required %0d %0d %b %b %b",
                 n, wr_ptr, wr_cnt, full, almost_full, overflow, m_wp, m_cnt, m_full, m_af, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ovf_clr();
    test_release();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: FIFO address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: write data width.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2: almost-full threshold, in entries.
REQ-004 SHALL have port clk, input, 1 bit: the single write-domain clock; all state is in this domain.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port wr_en, input, 1 bit: write request.
REQ-007 SHALL have port wr_data, input, DATA_WIDTH bits: write data.
REQ-008 SHALL have port rd_ptr_sync, input, ADDR_WIDTH+1 bits: binary read pointer, already resynchronised into clk by the pointer-crossing stage.
REQ-009 SHALL have port ovf_clr, input, 1 bit: clears the sticky overflow flag.
REQ-010 SHALL have port wr_ptr, output, ADDR_WIDTH+1 bits: binary write pointer; this is the counter input to the pointer-crossing stage toward the read domain.
REQ-011 SHALL have port mem_we, output, 1 bit: dual-port RAM write enable.
REQ-012 SHALL have port mem_waddr, output, ADDR_WIDTH bits: RAM write address.
REQ-013 SHALL have port mem_wdata, output, DATA_WIDTH bits: RAM write data.
REQ-014 SHALL have port full, output, 1 bit: FIFO full.
REQ-015 SHALL have port almost_full, output, 1 bit: level is at or above AF_LEVEL.
REQ-016 SHALL have port wr_cnt, output, ADDR_WIDTH+1 bits: write-side fill level.
REQ-017 SHALL have port overflow, output, 1 bit: sticky flag, set by a write attempted while full.

Function
REQ-018 A write SHALL be accepted in a cycle when wr_en=1 and full=0.
REQ-019 mem_we SHALL equal the accept condition combinationally.
REQ-020 mem_waddr SHALL equal wr_ptr[ADDR_WIDTH-1:0].
REQ-021 mem_wdata SHALL equal wr_data.
REQ-022 wr_ptr SHALL be a register that increments by 1 on each accepted write and wraps modulo 2**(ADDR_WIDTH+1) with no special handling.
REQ-023 wr_ptr_next SHALL be wr_ptr+1 if the write is accepted, else wr_ptr.
REQ-024 level_next SHALL be (wr_ptr_next - rd_ptr_sync) modulo 2**(ADDR_WIDTH+1).
REQ-025 wr_cnt SHALL be registered as level_next each cycle, giving 1-cycle latency from a write or a pointer change.
REQ-026 full SHALL be registered as (level_next == DEPTH), so full asserts in the cycle after the DEPTH-th outstanding write.
REQ-027 full SHALL deassert one cycle after rd_ptr_sync advances; full is conservative because the synchronised read pointer lags the true one.
REQ-028 Writes while full=1 SHALL be dropped: mem_we=0 and wr_ptr unchanged.
REQ-029 overflow SHALL set on any cycle with wr_en=1 and full=1.
REQ-030 overflow SHALL clear on ovf_clr=1; if set and clear occur in the same cycle, set wins.
REQ-031 An accepted write and a rd_ptr_sync change in the same cycle SHALL both be reflected in level_next.
REQ-032 The block SHALL contain no gray encoding; conversion belongs to the crossing stage.

Reset
REQ-033 On rst_n=0 the block SHALL asynchronously reset wr_ptr=0, wr_cnt=0, full=0, almost_full=0, overflow=0.
REQ-034 During reset, mem_we SHALL be 0.
REQ-035 Release of rst_n SHALL be synchronous to clk.
REQ-036 The first write SHALL be accepted in the first clk edge after release.
REQ-037 Reset mid-operation SHALL discard all state without completing in-flight writes.

Configuration
REQ-038 With macro FIFO_WR_ALMOST_FULL_EN defined, almost_full SHALL be registered as (level_next >= AF_LEVEL), with the same latency as full.
REQ-039 With FIFO_WR_ALMOST_FULL_EN undefined, almost_full SHALL be tied to 0, no comparator SHALL be synthesised, and the port SHALL remain present.

Verification
REQ-040 Scenario, fill (ADDR_WIDTH=4, rd_ptr_sync=0): 16 writes -> full=1 after the 16th, wr_cnt=16, wr_ptr=16; a 17th wr_en -> mem_we=0, overflow=1.
REQ-041 Scenario, release full: from full, set rd_ptr_sync=1 -> full=0 and wr_cnt=15 one cycle later; the next write is accepted at mem_waddr=0.
REQ-042 Scenario, wrap: 40 writes with rd_ptr_sync tracking to within 3 -> wr_ptr wraps 31->0, wr_cnt stays correct, full never asserts.
REQ-043 Scenario, simultaneous events: at wr_cnt=15, write and rd_ptr_sync +1 in the same cycle -> wr_cnt=15, full=0; ovf_clr together with wr_en while full -> overflow stays 1.
REQ-044 Scenario, almost-full: with FIFO_WR_ALMOST_FULL_EN and AF_LEVEL=14 -> almost_full=1 once wr_cnt=14; without the macro -> almost_full=0 throughout.
REQ-045 Scenario, reset mid-operation: rst_n pulsed low at wr_cnt=9 -> all outputs 0 immediately, without waiting for a clock edge.
